// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
package hazard_pkg;
    localparam int REG_ADDR_W = 5;
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef struct packed {
        reg_addr_t rs1;
        reg_addr_t rs2;
        reg_addr_t rd;
        logic      regwrite;
        logic      isload;
    } shadow_t;
    typedef struct packed {
        reg_addr_t rd;
        logic      regwrite;
    } dst_t;
    localparam shadow_t BUBBLE     = '0;
    localparam dst_t    DST_BUBBLE = '0;
endpackage

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: decode-stage operands and pipeline controls between core and hazard controller.
interface hazard_controller_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] Rs1_D;
    logic [REG_ADDR_W-1:0] Rs2_D;
    logic [REG_ADDR_W-1:0] Rd_D;
    logic                  RegWrite_D;
    logic                  ResultSrc_D;
    logic                  PCSrc_E;
    logic                  MemBusy_M;
    logic                  StallF;
    logic                  StallD;
    logic                  StallE;
    logic                  StallM;
    logic                  FlushD;
    logic                  FlushE;
    logic [1:0]            ForwardA_E;
    logic [1:0]            ForwardB_E;
    logic [CNT_W-1:0]      StallCount;
    logic [CNT_W-1:0]      FlushCount;
    modport master (
        output Rs1_D, Rs2_D, Rd_D, RegWrite_D, ResultSrc_D, PCSrc_E, MemBusy_M,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardA_E, ForwardB_E,
        input  StallCount, FlushCount
    );
    modport slave (
        input  Rs1_D, Rs2_D, Rd_D, RegWrite_D, ResultSrc_D, PCSrc_E, MemBusy_M,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardA_E, ForwardB_E,
        output StallCount, FlushCount
    );
endinterface

// File: rtl/forward_sel.sv
// forward_sel: picks the forwarding source for one E-stage operand, M over W, never x0.
module forward_sel
    import hazard_pkg::*;
(
    input  reg_addr_t  rs_i,
    input  reg_addr_t  rd_m_i,
    input  logic       regwrite_m_i,
    input  reg_addr_t  rd_w_i,
    input  logic       regwrite_w_i,
    output logic [1:0] fwd_o
);
    always_comb
        fwd_o = (regwrite_m_i && rd_m_i != '0 && rd_m_i == rs_i) ? FWD_M :
                (regwrite_w_i && rd_w_i != '0 && rd_w_i == rs_i) ? FWD_W : FWD_REG;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: shadow scoreboard of E/M/W driving stall, flush and forwarding controls,
// plus saturating load-use stall and branch flush counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic               clk,
    input logic               rst,
    hazard_controller_if.slave hz
);
    shadow_t          e_q, e_d;
    dst_t             m_q, m_d, w_q, w_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             lw_stall, busy, flush, stall;
    logic [1:0]       fwd_a, fwd_b;

    // One case per cycle: MemBusy freezes everything, then branch flush, then load-use.
    always_comb begin
        lw_stall = e_q.isload && e_q.regwrite && e_q.rd != '0 &&
                   (e_q.rd == hz.Rs1_D || e_q.rd == hz.Rs2_D);
        busy     = hz.MemBusy_M;
        flush    = !busy && hz.PCSrc_E;
        stall    = !busy && !hz.PCSrc_E && lw_stall;
    end

    forward_sel u_fwd_a (
        .rs_i(e_q.rs1), .rd_m_i(m_q.rd), .regwrite_m_i(m_q.regwrite),
        .rd_w_i(w_q.rd), .regwrite_w_i(w_q.regwrite), .fwd_o(fwd_a)
    );
    forward_sel u_fwd_b (
        .rs_i(e_q.rs2), .rd_m_i(m_q.rd), .regwrite_m_i(m_q.regwrite),
        .rd_w_i(w_q.rd), .regwrite_w_i(w_q.regwrite), .fwd_o(fwd_b)
    );

    always_comb begin
        e_d = busy ? e_q : (flush || stall) ? BUBBLE :
              '{rs1: hz.Rs1_D, rs2: hz.Rs2_D, rd: hz.Rd_D,
                regwrite: hz.RegWrite_D, isload: hz.ResultSrc_D};
        m_d = busy ? m_q : '{rd: e_q.rd, regwrite: e_q.regwrite};
        w_d = busy ? DST_BUBBLE : m_q;
        stall_cnt_d = stall_cnt_q + CNT_W'(stall && stall_cnt_q != '1);
        flush_cnt_d = flush_cnt_q + CNT_W'(flush && flush_cnt_q != '1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q         <= BUBBLE;
            m_q         <= DST_BUBBLE;
            w_q         <= DST_BUBBLE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            e_q         <= e_d;
            m_q         <= m_d;
            w_q         <= w_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.StallF     = !rst && (busy || stall);
    assign hz.StallD     = !rst && (busy || stall);
    assign hz.StallE     = !rst && busy;
    assign hz.StallM     = !rst && busy;
    assign hz.FlushD     = !rst && flush;
    assign hz.FlushE     = !rst && (flush || stall);
    assign hz.ForwardA_E = rst ? FWD_REG : fwd_a;
    assign hz.ForwardB_E = rst ? FWD_REG : fwd_b;
    assign hz.StallCount = rst ? '0 : stall_cnt_q;
    assign hz.FlushCount = rst ? '0 : flush_cnt_q;
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed vector table, random run against an in-flight instruction model,
// and a narrow-counter saturation sequence.
module tb_hazard_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    hazard_controller_if #(.REG_ADDR_W(5), .CNT_W(32)) hz ();
    hazard_controller_if #(.REG_ADDR_W(5), .CNT_W(2))  hz2 ();
    hazard_controller #(.CNT_W(32)) dut  (.clk(clk), .rst(rst),  .hz(hz));
    hazard_controller #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst2), .hz(hz2));

    wire [9:0] ctrl = {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE,
                       hz.ForwardA_E, hz.ForwardB_E};
    localparam logic [9:0] SF = 10'h200, SD = 10'h100, SE = 10'h080, SM = 10'h040;
    localparam logic [9:0] FD = 10'h020, FE = 10'h010, FA_M = 10'h008, FA_W = 10'h004;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic [4:0] rs1, rs2, rd,
                         input logic wr, ld, pc, busy);
        rst = r;
        hz.Rs1_D = rs1; hz.Rs2_D = rs2; hz.Rd_D = rd;
        hz.RegWrite_D = wr; hz.ResultSrc_D = ld; hz.PCSrc_E = pc; hz.MemBusy_M = busy;
    endtask

    typedef struct {
        logic       r;
        logic [4:0] rs1, rs2, rd;
        logic       wr, ld, pc, busy;
        logic [9:0] ctrl;
        int         sc, fc;
    } vec_t;

    function automatic vec_t v(input logic r, input logic [4:0] rs1, rs2, rd,
                               input logic wr, ld, pc, busy,
                               input logic [9:0] c, input int sc, fc);
        v = '{r, rs1, rs2, rd, wr, ld, pc, busy, c, sc, fc};
    endfunction

    // Reference: a 3-entry list of in-flight instructions, index 0 = E, 1 = M, 2 = W.
    typedef struct { logic [4:0] rs1, rs2, rd; logic wr, ld; } ins_t;
    ins_t pipe[3];
    int   msc, mfc;

    function automatic logic [1:0] mfwd(input logic [4:0] rs);
        for (int k = 1; k < 3; k++)
            if (pipe[k].wr && pipe[k].rd != 0 && pipe[k].rd == rs) return (k == 1) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic logic mlw();
        return pipe[0].ld && pipe[0].wr && pipe[0].rd != 0 &&
               (pipe[0].rd == hz.Rs1_D || pipe[0].rd == hz.Rs2_D);
    endfunction

    function automatic logic [9:0] mexp();
        if (rst) return 10'd0;
        if (hz.MemBusy_M) return SF | SD | SE | SM | {6'd0, mfwd(pipe[0].rs1), mfwd(pipe[0].rs2)};
        if (hz.PCSrc_E) return FD | FE | {6'd0, mfwd(pipe[0].rs1), mfwd(pipe[0].rs2)};
        if (mlw()) return SF | SD | FE | {6'd0, mfwd(pipe[0].rs1), mfwd(pipe[0].rs2)};
        return {6'd0, mfwd(pipe[0].rs1), mfwd(pipe[0].rs2)};
    endfunction

    task automatic mstep();
        ins_t bub = '{0, 0, 0, 0, 0};
        ins_t d = '{hz.Rs1_D, hz.Rs2_D, hz.Rd_D, hz.RegWrite_D, hz.ResultSrc_D};
        logic lw = mlw();
        if (rst) begin
            pipe[0] = bub; pipe[1] = bub; pipe[2] = bub; msc = 0; mfc = 0;
        end else if (hz.MemBusy_M) begin
            pipe[2] = bub;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (hz.PCSrc_E || lw) ? bub : d;
            if (hz.PCSrc_E) mfc++;
            else if (lw) msc++;
        end
    endtask

    vec_t vecs[$];

    initial begin
        hz2.Rs1_D = '0; hz2.Rs2_D = '0; hz2.Rd_D = '0; hz2.RegWrite_D = 0;
        hz2.ResultSrc_D = 0; hz2.PCSrc_E = 0; hz2.MemBusy_M = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        vecs.push_back(v(1, 1, 2, 5, 1, 0, 1, 1, 0, 0, 0));
        vecs.push_back(v(0, 1, 2, 5, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 5, 3, 6, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, FA_M, 0, 0));
        vecs.push_back(v(0, 1, 2, 5, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 5, 3, 6, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, FA_W, 0, 0));
        vecs.push_back(v(0, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 7, 2, 8, 1, 0, 0, 0, SF | SD | FE, 0, 0));
        vecs.push_back(v(0, 7, 2, 8, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, FA_W, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 9, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 1, 0, 7, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 7, 2, 8, 1, 0, 1, 0, FD | FE, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(v(0, 1, 2, 5, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(v(0, 5, 3, 6, 1, 0, 0, 0, 0, 1, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, SF | SD | SE | SM | FA_M, 1, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, FD | FE | FA_M, 1, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
        vecs.push_back(v(0, 1, 0, 7, 1, 1, 0, 0, 0, 1, 2));
        vecs.push_back(v(1, 7, 2, 8, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 7, 2, 8, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].r, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                  vecs[i].wr, vecs[i].ld, vecs[i].pc, vecs[i].busy);
            #1;
            chk($sformatf("vec%0d ctrl", i), 64'(ctrl), 64'(vecs[i].ctrl));
            chk($sformatf("vec%0d counters", i), {hz.StallCount, hz.FlushCount},
                {32'(vecs[i].sc), 32'(vecs[i].fc)});
        end

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            drive(c == 0 || $urandom_range(63) == 0,
                  5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                  1'($urandom_range(3) != 0), 1'($urandom_range(1)),
                  $urandom_range(5) == 0, $urandom_range(3) == 0);
            #1;
            chk($sformatf("rand%0d ctrl", c), 64'(ctrl), 64'(mexp()));
            chk($sformatf("rand%0d counters", c), {hz.StallCount, hz.FlushCount},
                rst ? 64'd0 : {32'(msc), 32'(mfc)});
            mstep();
        end

        // Back-to-back lw x7,0(x7): a load-use stall every other cycle against a 2-bit counter.
        @(negedge clk);
        rst2 = 0;
        hz2.Rs1_D = 5'd7; hz2.Rd_D = 5'd7; hz2.RegWrite_D = 1; hz2.ResultSrc_D = 1;
        repeat (4) @(negedge clk);
        #1 chk("sat after 2 stalls", 64'(hz2.StallCount), 64'd2);
        repeat (6) @(negedge clk);
        #1 chk("sat after 5 stalls", 64'(hz2.StallCount), 64'd3);
        chk("sat flush count", 64'(hz2.FlushCount), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
